// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry add/subtract: WIDTH bits split into STAGES slices, one
// register stage per slice, valid/ready handshake with a global stall.
module pipelined_rc_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SLICE = WIDTH / STAGES;

  generate
    if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_rc_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end
  endgenerate

  // Returns {carry into slice MSB, carry out of slice MSB, slice sum}.
  function automatic logic [SLICE+1:0] ripple_slice(input logic [SLICE-1:0] x,
                                                    input logic [SLICE-1:0] y,
                                                    input logic             cin);
    logic             c;
    logic             c_msb;
    logic [SLICE-1:0] s;
    c     = cin;
    c_msb = cin;
    s     = '0;
    for (int i = 0; i < SLICE; i++) begin
      c_msb = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c_msb, c, s};
  endfunction

  logic [STAGES-1:0]                vld_q;
  logic [STAGES-1:0][WIDTH-1:0]     a_q, b_q, res_q;
  logic [STAGES-1:0]                cy_q;
  logic [WIDTH-1:0]                 sum_q;
  logic                             co_q, ovf_q;

  logic [STAGES-1:0]                s_v, s_c;
  logic [STAGES-1:0][WIDTH-1:0]     s_a, s_b, s_r;
  logic [STAGES-1:0][SLICE+1:0]     fa;
  logic [STAGES-1:0][WIDTH-1:0]     res_d;
  logic                             ovf_d;
  logic                             stall, en;

  assign stall    = vld_q[STAGES-1] & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  // Stage k consumes the operands carried by stage k-1; stage 0 takes the ports.
  always_comb begin
    s_v[0] = in_valid;
    s_a[0] = a;
    s_b[0] = sub ? ~b : b;
    s_r[0] = '0;
    s_c[0] = sub | carry_in;
    for (int k = 1; k < STAGES; k++) begin
      s_v[k] = vld_q[k-1];
      s_a[k] = a_q[k-1];
      s_b[k] = b_q[k-1];
      s_r[k] = res_q[k-1];
      s_c[k] = cy_q[k-1];
    end
  end

  always_comb begin
    fa    = '0;
    res_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      fa[k]                       = ripple_slice(s_a[k][k*SLICE +: SLICE],
                                                 s_b[k][k*SLICE +: SLICE], s_c[k]);
      res_d[k]                    = s_r[k];
      res_d[k][k*SLICE +: SLICE]  = fa[k][SLICE-1:0];
    end
    ovf_d = fa[STAGES-1][SLICE+1] ^ fa[STAGES-1][SLICE];
  end

  // Stage registers: data loads only with a valid beat so idle X never enters.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (en && s_v[k]) begin
        a_q[k]   <= s_a[k];
        b_q[k]   <= s_b[k];
        res_q[k] <= res_d[k];
        cy_q[k]  <= fa[k][SLICE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= s_v;
      if (s_v[STAGES-1]) begin
        sum_q <= res_d[STAGES-1];
        co_q  <= fa[STAGES-1][SLICE];
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q;
  assign carry_out = co_q;
  assign overflow  = ovf_q;

  // Consumed operand bits and the last stage's intermediate copies are dead.
  logic unused_ok;
  assign unused_ok = ^{s_a, s_b, s_r, a_q, b_q, res_q, cy_q, fa};

endmodule

// File: doc/pipelined_rc_adder.md
Name: pipelined_rc_adder

Overview:
- Parametrised, pipelined successor to the 4-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple-carry slices, with one register stage per slice.
- Provides a valid/ready handshake, add/sub mode, and carry-out and signed-overflow flags.
- Sits on datapath paths where a full-width ripple chain would miss timing; sustains one operation per clock.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- STAGES, 4, pipeline depth; WIDTH % STAGES == 0 required, enforced by elaboration-time check.
- SLICE, WIDTH/STAGES, derived localparam; bits added per stage by a ripple chain of full-adder cells.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  carry into bit 0; ignored when sub=1
- sub  input  1  0: a+b+carry_in; 1: a+~b+1 (a−b)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- carry_out  output  1  carry out of MSB (sub: 1 = no borrow)
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, async):
  - All stage valid bits, out_valid, sum, carry_out and overflow clear to 0.
  - in_ready = 1 once out of reset.
  - Reset mid-operation discards all in-flight beats; no partial result ever appears.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stall and enable:
  - stall = out_valid && !out_ready. Global enable en = !stall; in_ready = !stall (combinational).
  - When stall=1, every stage register holds, including bubbles. Sum and flags stay stable while out_valid=1 and out_ready=0.
- Stage k (0..STAGES-1):
  - Adds slice k of A with slice k of B (B inverted if sub).
  - Carry in is the registered carry from stage k−1; stage 0 uses carry_in, or 1 when sub=1.
  - Lower result slices and upper unconsumed operand slices are carried forward in the stage registers.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stalls.
- Throughput: 1 beat/cycle. Bubbles (in_valid=0) propagate as valid=0.
- Ordering: results leave in input order. No reordering or dropping.
- Flags: overflow is computed in the last stage from the MSB carries. STAGES=1 degenerates to one registered ripple adder.
- Simultaneous in/out transfer on a full pipe is allowed (in_ready=1 whenever out_ready=1).
- Wrap-around: results are modulo 2^WIDTH, e.g. 0xFFFF+1 → sum 0x0000, carry_out=1.
- No X on outputs after reset even with X on idle inputs: gate register loads by valid.

Test Plan (WIDTH=16, STAGES=4):
1. Reset then a=0x1234, b=0x0FED, carry_in=1, sub=0, single beat -> out_valid exactly 4 cycles later; sum=0x2222, carry_out=0, overflow=0.
2. Carry chain across all slices: a=0xFFFF, b=0x0001, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0. Also a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1.
3. Subtract mode: a=0x0005, b=0x0007, sub=1, carry_in=1 (ignored) -> sum=0xFFFE, carry_out=0. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, overflow=1.
4. Back-to-back stream of 100 random beats with out_ready=1 -> 100 results in order, one per cycle after 4-cycle fill, all matching a reference model.
5. Random out_ready backpressure (50%) with continuous in_valid -> in_ready low exactly when out_valid && !out_ready. Outputs stable during stall; no loss or duplication; scoreboard matches.
6. Assert rst_n low for 1 cycle with 3 beats in flight -> out_valid, sum and flags go 0 immediately. No stale results after release; next beat completes with a 4-cycle latency.
